// File: rtl/reduce_seq_if.sv
// Request/result handshake bundle for reduce_seq: vector + opcode in, 1-bit result out.
interface reduce_seq_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic [1:0]       in_op;
    logic             out_valid;
    logic             out_ready;
    logic             out_result;

    modport master (
        output in_valid, in_data, in_op, out_ready,
        input  in_ready, out_valid, out_result
    );

    modport slave (
        input  in_valid, in_data, in_op, out_ready,
        output in_ready, out_valid, out_result
    );
endinterface

// File: rtl/reduce_seq.sv
// Sequential AND/OR/XOR/NAND reducer folding CHUNK bits per cycle; latency NCHUNK cycles accept-to-result.
// Single request in flight: in_ready low in RUN/DONE, result held until out_ready. Option: REDUCE_SEQ_EARLY_EXIT_EN.
module reduce_seq #(
    parameter int WIDTH = 32,
    parameter int CHUNK = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    reduce_seq_if.slave   bus
);
    localparam int NCHUNK = (WIDTH + CHUNK - 1) / CHUNK;
    localparam int SW     = NCHUNK * CHUNK;
    localparam int CW     = $clog2(NCHUNK + 1);

    localparam logic [1:0] OP_AND  = 2'b00;
    localparam logic [1:0] OP_OR   = 2'b01;
    localparam logic [1:0] OP_XOR  = 2'b10;
    localparam logic [1:0] OP_NAND = 2'b11;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t          state, state_nxt;
    logic [SW-1:0]   shreg;
    logic [SW-1:0]   shreg_init;
    logic [1:0]      op;
    logic            acc;
    logic            acc_nxt;
    logic [CW-1:0]   cnt;
    logic            ident_in;
    logic            last;
    logic            absorb;
    logic            accept;
    logic            in_ready_c;
    logic            out_valid_c;

    // Bits above WIDTH are preloaded with the identity so the last chunk folds as a no-op there.
    always_comb begin
        ident_in   = (bus.in_op == OP_AND) || (bus.in_op == OP_NAND);
        shreg_init = {SW{ident_in}};
        shreg_init[WIDTH-1:0] = bus.in_data;
    end

    always_comb begin
        acc_nxt = acc;
        case (op)
            OP_OR:   acc_nxt = acc | (|shreg[CHUNK-1:0]);
            OP_XOR:  acc_nxt = acc ^ (^shreg[CHUNK-1:0]);
            default: acc_nxt = acc & (&shreg[CHUNK-1:0]);
        endcase
    end

    assign last = (cnt == CW'(NCHUNK - 1));

`ifdef REDUCE_SEQ_EARLY_EXIT_EN
    // Once AND hits 0 or OR hits 1 the remaining chunks cannot change the result.
    always_comb begin
        absorb = 1'b0;
        case (op)
            OP_OR:   absorb = acc_nxt;
            OP_XOR:  absorb = 1'b0;
            default: absorb = ~acc_nxt;
        endcase
    end
`else
    assign absorb = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        accept      = 1'b0;
        in_ready_c  = 1'b0;
        out_valid_c = 1'b0;
        case (state)
            IDLE: begin
                in_ready_c = 1'b1;
                if (bus.in_valid) begin
                    accept    = 1'b1;
                    state_nxt = RUN;
                end
            end
            RUN: begin
                if (last || absorb) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                out_valid_c = 1'b1;
                if (bus.out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shreg <= '0;
            op    <= OP_AND;
            acc   <= 1'b0;
            cnt   <= '0;
        end else if (accept) begin
            shreg <= shreg_init;
            op    <= bus.in_op;
            acc   <= ident_in;
            cnt   <= '0;
        end else if (state == RUN) begin
            shreg <= shreg >> CHUNK;
            acc   <= acc_nxt;
            cnt   <= cnt + CW'(1);
        end
    end

    assign bus.in_ready   = in_ready_c;
    assign bus.out_valid  = out_valid_c;
    // NAND is accumulated as AND and only inverted at the output.
    assign bus.out_result = out_valid_c & (acc ^ (op == OP_NAND));

endmodule
